// File: rtl/hazard3_regfile_ctrl.sv
// hazard3_regfile_ctrl
//   Front end for a 1-write/2-read register file without its own reset.
//   - Clears every register after reset (INIT), then hands the file to the core.
//   - Arbitrates core writeback against debug abstract-register access.
//   - Hard-wires x0 and forwards a same-cycle write to the registered read data.
// Ports
//   clk, rst_n                       clock, async active-low reset
//   core_raddr1/2, core_rdata1/2     core read ports, 1-cycle latency
//   core_waddr/wdata/wen             core writeback
//   core_stall                       file unavailable to the core this cycle
//   init_done                        clear sequence complete (sticky)
//   dbg_halted/req/write/addr/wdata  debug request (held until dbg_ack)
//   dbg_ack, dbg_rdata               one-cycle completion pulse and read result
//   rf_*                             regfile ports (hazard3_regfile_1w2r)
module hazard3_regfile_ctrl #(
  parameter int N_REGS = 32,
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] core_raddr1,
  input  logic [W_ADDR-1:0] core_raddr2,
  output logic [W_DATA-1:0] core_rdata1,
  output logic [W_DATA-1:0] core_rdata2,
  input  logic [W_ADDR-1:0] core_waddr,
  input  logic [W_DATA-1:0] core_wdata,
  input  logic              core_wen,
  output logic              core_stall,
  output logic              init_done,
  input  logic              dbg_halted,
  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [W_ADDR-1:0] dbg_addr,
  input  logic [W_DATA-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [W_DATA-1:0] dbg_rdata,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              rf_wen
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_DBG_ISSUE = 3'd2;
  localparam logic [2:0] S_DBG_RESP  = 3'd3;
  localparam logic [2:0] S_DBG_WAIT  = 3'd4;

  localparam logic [W_ADDR-1:0] LAST_REG = W_ADDR'(N_REGS - 1);

  logic [2:0]        state_q, state_d;
  logic [W_ADDR-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  // Read-side flags captured alongside the regfile's own read register.
  logic              zero1_q, zero2_q, byp1_q, byp2_q;
  logic [W_DATA-1:0] wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rf_raddr1   = core_raddr1;
    rf_raddr2   = core_raddr2;
    rf_wen      = 1'b0;
    rf_waddr    = core_waddr;
    rf_wdata    = core_wdata;
    dbg_ack     = 1'b0;
    dbg_rdata   = '0;
    case (state_q)
      S_INIT: begin
        rf_wen   = 1'b1;
        rf_waddr = cnt_q;
        rf_wdata = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_REG) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN: begin
        rf_wen = core_wen && (core_waddr != '0);
        // A core write in the same cycle wins; debug simply retries next cycle.
        if (dbg_req && dbg_halted && !core_wen) state_d = S_DBG_ISSUE;
      end
      S_DBG_ISSUE: begin
        rf_raddr1 = dbg_addr;
        if (dbg_write && (dbg_addr != '0)) begin
          rf_wen   = 1'b1;
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
        state_d = S_DBG_RESP;
      end
      S_DBG_RESP: begin
        dbg_ack = 1'b1;
        if (!dbg_write && (dbg_addr != '0)) dbg_rdata = rf_rdata1;
        state_d = S_DBG_WAIT;
      end
      S_DBG_WAIT: begin
        // Wait for the requester to drop req so a held request is not re-issued.
        if (!dbg_req) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      zero1_q     <= 1'b0;
      zero2_q     <= 1'b0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      zero1_q     <= (rf_raddr1 == '0);
      zero2_q     <= (rf_raddr2 == '0);
      byp1_q      <= rf_wen && (rf_waddr == rf_raddr1);
      byp2_q      <= rf_wen && (rf_waddr == rf_raddr2);
      wdata_q     <= rf_wdata;
    end
  end

  // The regfile returns pre-write data on a same-cycle collision, hence the bypass.
  assign core_rdata1 = zero1_q ? '0 : (byp1_q ? wdata_q : rf_rdata1);
  assign core_rdata2 = zero2_q ? '0 : (byp2_q ? wdata_q : rf_rdata2);
  assign core_stall  = (state_q != S_RUN);
  assign init_done   = init_done_q;

endmodule
